// File: rtl/mem_resp.sv
// Wait-state memory responder: holds kp for WAIT_CYC cycles, then completes a read or write on an internal RAM.
// Optional MEMRESP_ERR_EN adds an err output that flags accesses with adr >= DEPTH.
module mem_resp #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              kp
`ifdef MEMRESP_ERR_EN
  ,
  output logic              err
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              kp_nxt;
  logic              lat_en;
  logic              acc_fire;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_adr;
  logic [DATA_W-1:0] acc_wdata;
  logic              in_rng;
  logic [IDX_W-1:0]  idx;

  logic              we_p0;
  logic [ADDR_W-1:0] adr_p0;
  logic [DATA_W-1:0] wdata_p0;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      kp    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      kp    <= kp_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req && (WAIT_CYC != 0)) state_nxt = BUSY;
      BUSY: if (cnt <= 4'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // In IDLE the access (zero wait states) uses the live bus; in BUSY it uses the latched request.
  always_comb begin
    lat_en    = 1'b0;
    acc_fire  = 1'b0;
    kp_nxt    = kp;
    cnt_nxt   = cnt;
    acc_we    = we;
    acc_adr   = adr;
    acc_wdata = wdata;
    case (state)
      IDLE: begin
        if (req) begin
          lat_en = 1'b1;
          if (WAIT_CYC == 0) begin
            acc_fire = 1'b1;
          end else begin
            cnt_nxt = WAIT_INIT;
            kp_nxt  = 1'b1;
          end
        end
      end
      BUSY: begin
        acc_we    = we_p0;
        acc_adr   = adr_p0;
        acc_wdata = wdata_p0;
        cnt_nxt   = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          acc_fire = 1'b1;
          kp_nxt   = 1'b0;
          cnt_nxt  = '0;
        end
      end
      default: ;
    endcase
  end

  // p0: request capture, held stable for the whole BUSY window
  always_ff @(posedge clk) begin
    if (lat_en) begin
      we_p0    <= we;
      adr_p0   <= adr;
      wdata_p0 <= wdata;
    end
  end

`ifdef MEMRESP_ERR_EN
  assign in_rng = ({1'b0, acc_adr} < (ADDR_W + 1)'(DEPTH));
`else
  assign in_rng = 1'b1;
`endif
  assign idx = acc_adr[IDX_W-1:0];

  // Completion edge: RAM write or registered read
  always_ff @(posedge clk) begin
    if (!rst && acc_fire && acc_we && in_rng) mem[idx] <= acc_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (acc_fire && !acc_we) begin
      rdata <= in_rng ? mem[idx] : '0;
    end
  end

`ifdef MEMRESP_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else     err <= acc_fire && !in_rng;
  end
`endif

endmodule
